id_ex_operand_stage: RTL and testbench

ID/EX pipeline register and operand-select stage that sits directly upstream of the ALU.
- Captures decoded fields from ID.
- Forwards results from EX/MEM and MEM/WB.
- Selects the immediate or the register value for operand B.
- Drives ALUOperation, A and B to the ALU.
- Detects load-use hazards and inserts bubbles.
- Supports flush (taken branch/jump) and downstream hold.

---
 rtl/id_ex_operand_stage.sv | 219 +++++++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
// ID/EX pipeline register plus the operand-select logic that feeds the ALU.
// Captures decoded ID fields and forwards EX/MEM and MEM/WB results onto the
// registered rs/rt operands. Picks immediate or rt for operand B. Detects
// load-use hazards, inserts a one-cycle bubble, and honours flush/hold.
//
// Optional build macro: STALL_COUNTER_EN adds a free-running 32-bit count of
// the load-use bubbles actually inserted (output stall_count).
//
// Stage advance semantics (the only "handshake" this stage has):
//   - stall_id=1 tells IF/ID to keep the current ID instruction.
//     stall_id = load_use | ex_hold, and it is forced low during reset.
//   - ex_hold=1 freezes every register of this stage. Downstream is not
//     advancing.
//   - flush=1 drops whatever would be captured this edge (ex_valid<=0).
//     flush wins over ex_hold and load_use.
//   - Priority each clock edge: reset > flush > ex_hold > load_use > capture.
module id_ex_operand_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int OP_WIDTH       = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      id_valid,
   input  logic [OP_WIDTH-1:0]       id_alu_op,
   input  logic [DATA_WIDTH-1:0]     id_rs_data,
   input  logic [DATA_WIDTH-1:0]     id_rt_data,
   input  logic [DATA_WIDTH-1:0]     id_imm,
   input  logic                      id_alu_src,
   input  logic                      id_uses_rt,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs_addr,
   input  logic [REG_ADDR_WIDTH-1:0] id_rt_addr,
   input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
   input  logic                      id_reg_write,
   input  logic                      id_mem_read,
   input  logic                      exmem_reg_write,
   input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_addr,
   input  logic [DATA_WIDTH-1:0]     exmem_result,
   input  logic                      memwb_reg_write,
   input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_addr,
   input  logic [DATA_WIDTH-1:0]     memwb_result,
   input  logic                      flush,
   input  logic                      ex_hold,
`ifdef STALL_COUNTER_EN
   output logic [31:0]               stall_count,
`endif
   output logic                      stall_id,
   output logic                      ex_valid,
   output logic [OP_WIDTH-1:0]       ALUOperation,
   output logic [DATA_WIDTH-1:0]     A,
   output logic [DATA_WIDTH-1:0]     B,
   output logic [DATA_WIDTH-1:0]     ex_store_data,
   output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
   output logic                      ex_reg_write,
   output logic                      ex_mem_read
);

   // Forwarding source encoding. Kept as named signals so a checker can
   // observe which path fed each operand.
   localparam logic [1:0] FWD_REG   = 2'd0;
   localparam logic [1:0] FWD_EXMEM = 2'd1;
   localparam logic [1:0] FWD_MEMWB = 2'd2;

   // ------------------------------------------------------------------
   // Pipeline registers
   // ------------------------------------------------------------------
   logic                      valid_q;
   logic [OP_WIDTH-1:0]       alu_op_q;
   logic [DATA_WIDTH-1:0]     rs_data_q;
   logic [DATA_WIDTH-1:0]     rt_data_q;
   logic [DATA_WIDTH-1:0]     imm_q;
   logic                      alu_src_q;
   logic [REG_ADDR_WIDTH-1:0] rs_addr_q;
   logic [REG_ADDR_WIDTH-1:0] rt_addr_q;
   logic [REG_ADDR_WIDTH-1:0] rd_addr_q;
   logic                      reg_write_q;
   logic                      mem_read_q;

   // Hazard and forwarding internals
   logic                      load_use;
   logic                      rs_hit;
   logic                      rt_hit;
   logic [1:0]                fwd_rs_sel;
   logic [1:0]                fwd_rt_sel;
   logic [DATA_WIDTH-1:0]     fwd_rs;
   logic [DATA_WIDTH-1:0]     fwd_rt;

   // Select a forwarding source for one registered operand address.
   // EX/MEM is the younger producer, so it wins over MEM/WB.
   // r0 is hard-wired zero and is never forwarded.
   function automatic logic [1:0] fwd_select(
      input logic [REG_ADDR_WIDTH-1:0] addr,
      input logic                      em_we,
      input logic [REG_ADDR_WIDTH-1:0] em_rd,
      input logic                      mw_we,
      input logic [REG_ADDR_WIDTH-1:0] mw_rd
   );
      logic [1:0] sel;
      sel = FWD_REG;
      if (em_we && (em_rd != '0) && (em_rd == addr)) begin
         sel = FWD_EXMEM;
      end else if (mw_we && (mw_rd != '0) && (mw_rd == addr)) begin
         sel = FWD_MEMWB;
      end
      return sel;
   endfunction

   // Load-use detection: a valid load in this stage whose destination is read
   // by the ID instruction. rt only counts when the instruction really reads it.
   always_comb begin
      rs_hit   = (rd_addr_q == id_rs_addr);
      rt_hit   = id_uses_rt && (rd_addr_q == id_rt_addr);
      load_use = valid_q && mem_read_q && (rd_addr_q != '0) && id_valid &&
                 (rs_hit || rt_hit);
   end

   // Freeze request upstream. Held low while reset is asserted.
   always_comb begin
      stall_id = 1'b0;
      if (!reset) begin
         stall_id = load_use || ex_hold;
      end
   end

   // Stage register update. Priority: reset > flush > hold > bubble > capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q     <= 1'b0;
         alu_op_q    <= '0;
         rs_data_q   <= '0;
         rt_data_q   <= '0;
         imm_q       <= '0;
         alu_src_q   <= 1'b0;
         rs_addr_q   <= '0;
         rt_addr_q   <= '0;
         rd_addr_q   <= '0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (!ex_hold) begin
         if (load_use) begin
            valid_q <= 1'b0;
         end else begin
            valid_q     <= id_valid;
            alu_op_q    <= id_alu_op;
            rs_data_q   <= id_rs_data;
            rt_data_q   <= id_rt_data;
            imm_q       <= id_imm;
            alu_src_q   <= id_alu_src;
            rs_addr_q   <= id_rs_addr;
            rt_addr_q   <= id_rt_addr;
            rd_addr_q   <= id_rd_addr;
            reg_write_q <= id_reg_write;
            mem_read_q  <= id_mem_read;
         end
      end
   end

   // Forwarding source selection for the registered rs and rt addresses.
   always_comb begin
      fwd_rs_sel = fwd_select(rs_addr_q, exmem_reg_write, exmem_rd_addr,
                              memwb_reg_write, memwb_rd_addr);
      fwd_rt_sel = fwd_select(rt_addr_q, exmem_reg_write, exmem_rd_addr,
                              memwb_reg_write, memwb_rd_addr);
   end

   // Forwarded operand values, a zero-cycle path from the later stages.
   always_comb begin
      unique case (fwd_rs_sel)
         FWD_EXMEM: fwd_rs = exmem_result;
         FWD_MEMWB: fwd_rs = memwb_result;
         default:   fwd_rs = rs_data_q;
      endcase
      unique case (fwd_rt_sel)
         FWD_EXMEM: fwd_rt = exmem_result;
         FWD_MEMWB: fwd_rt = memwb_result;
         default:   fwd_rt = rt_data_q;
      endcase
   end

   // ALU-facing outputs. A bubble drives zero operands and op AND (0000),
   // so the ALU Zero flag is deterministic when the stage is empty.
   always_comb begin
      ex_valid      = valid_q;
      ex_store_data = fwd_rt;
      ex_rd_addr    = rd_addr_q;
      ALUOperation  = '0;
      A             = '0;
      B             = '0;
      ex_reg_write  = 1'b0;
      ex_mem_read   = 1'b0;
      if (valid_q) begin
         ALUOperation = alu_op_q;
         A            = fwd_rs;
         B            = alu_src_q ? imm_q : fwd_rt;
         ex_reg_write = reg_write_q;
         ex_mem_read  = mem_read_q;
      end
   end

`ifdef STALL_COUNTER_EN
   logic [31:0] stall_cnt_q;

   // Count only the bubbles actually inserted. A flushed or held edge
   // inserts none. The counter wraps naturally at 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else if (load_use && !flush && !ex_hold) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Testbench for id_ex_operand_stage.
// Runs directed scenarios plus a short random capture loop.
// Expected ALU-side results {valid, op, A, B} are queued when ID stimulus is
// driven. They are popped and compared one clock after capture.
module tb_id_ex_operand_stage;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int OW = 4;
   localparam int W  = 1 + OW + DW + DW;

   logic          clk;
   logic          reset;
   logic          id_valid;
   logic [OW-1:0] id_alu_op;
   logic [DW-1:0] id_rs_data;
   logic [DW-1:0] id_rt_data;
   logic [DW-1:0] id_imm;
   logic          id_alu_src;
   logic          id_uses_rt;
   logic [AW-1:0] id_rs_addr;
   logic [AW-1:0] id_rt_addr;
   logic [AW-1:0] id_rd_addr;
   logic          id_reg_write;
   logic          id_mem_read;
   logic          exmem_reg_write;
   logic [AW-1:0] exmem_rd_addr;
   logic [DW-1:0] exmem_result;
   logic          memwb_reg_write;
   logic [AW-1:0] memwb_rd_addr;
   logic [DW-1:0] memwb_result;
   logic          flush;
   logic          ex_hold;
   logic          stall_id;
   logic          ex_valid;
   logic [OW-1:0] ALUOperation;
   logic [DW-1:0] A;
   logic [DW-1:0] B;
   logic [DW-1:0] ex_store_data;
   logic [AW-1:0] ex_rd_addr;
   logic          ex_reg_write;
   logic          ex_mem_read;
`ifdef STALL_COUNTER_EN
   logic [31:0]   stall_count;
`endif

   logic [W-1:0]  exp_q[$];
   int            vec_cnt;
   int            err_cnt;

   id_ex_operand_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .OP_WIDTH(OW)) dut (
      .clk             (clk),
      .reset           (reset),
      .id_valid        (id_valid),
      .id_alu_op       (id_alu_op),
      .id_rs_data      (id_rs_data),
      .id_rt_data      (id_rt_data),
      .id_imm          (id_imm),
      .id_alu_src      (id_alu_src),
      .id_uses_rt      (id_uses_rt),
      .id_rs_addr      (id_rs_addr),
      .id_rt_addr      (id_rt_addr),
      .id_rd_addr      (id_rd_addr),
      .id_reg_write    (id_reg_write),
      .id_mem_read     (id_mem_read),
      .exmem_reg_write (exmem_reg_write),
      .exmem_rd_addr   (exmem_rd_addr),
      .exmem_result    (exmem_result),
      .memwb_reg_write (memwb_reg_write),
      .memwb_rd_addr   (memwb_rd_addr),
      .memwb_result    (memwb_result),
      .flush           (flush),
      .ex_hold         (ex_hold),
`ifdef STALL_COUNTER_EN
      .stall_count     (stall_count),
`endif
      .stall_id        (stall_id),
      .ex_valid        (ex_valid),
      .ALUOperation    (ALUOperation),
      .A               (A),
      .B               (B),
      .ex_store_data   (ex_store_data),
      .ex_rd_addr      (ex_rd_addr),
      .ex_reg_write    (ex_reg_write),
      .ex_mem_read     (ex_mem_read)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void push_exp(input logic v, input logic [OW-1:0] op,
                                    input logic [DW-1:0] a, input logic [DW-1:0] b);
      exp_q.push_back({v, op, a, b});
   endfunction

   // Advance one clock, then compare the ALU-facing outputs with the oldest expectation.
   task automatic step();
      logic [W-1:0] e;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check("ex_valid", 32'(ex_valid), 32'(e[W-1]));
         check("alu_op", 32'(ALUOperation), 32'(e[W-2 -: OW]));
         check("a", A, e[2*DW-1 -: DW]);
         check("b", B, e[DW-1:0]);
      end
   endtask

   task automatic idle_id();
      id_valid = 1'b0; id_alu_op = '0; id_rs_data = '0; id_rt_data = '0;
      id_imm = '0; id_alu_src = 1'b0; id_uses_rt = 1'b0; id_rs_addr = '0;
      id_rt_addr = '0; id_rd_addr = '0; id_reg_write = 1'b0; id_mem_read = 1'b0;
   endtask

   task automatic idle_fwd();
      exmem_reg_write = 1'b0; exmem_rd_addr = '0; exmem_result = '0;
      memwb_reg_write = 1'b0; memwb_rd_addr = '0; memwb_result = '0;
   endtask

   task automatic cap(input logic [OW-1:0] op, input logic [DW-1:0] rsd, input logic [DW-1:0] rtd,
                      input logic [DW-1:0] imm, input logic src, input logic urt,
                      input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                      input logic rw, input logic mr);
      id_valid = 1'b1; id_alu_op = op; id_rs_data = rsd; id_rt_data = rtd;
      id_imm = imm; id_alu_src = src; id_uses_rt = urt; id_rs_addr = rs;
      id_rt_addr = rt; id_rd_addr = rd; id_reg_write = rw; id_mem_read = mr;
   endtask

   initial begin
      logic [OW-1:0] r_op;
      logic [DW-1:0] r_rs, r_rt, r_imm;
      logic          r_src;
      vec_cnt = 0;
      err_cnt = 0;
      idle_id();
      idle_fwd();
      flush = 1'b0;

      // Reset with hold asserted: stall_id must stay low during reset.
      reset   = 1'b1;
      ex_hold = 1'b1;
      push_exp(1'b0, 4'd0, 32'd0, 32'd0);
      step();
      check("rst_stall_id", 32'(stall_id), 32'd0);
      check("rst_rd_addr", 32'(ex_rd_addr), 32'd0);
      check("rst_store", ex_store_data, 32'd0);
      check("rst_reg_write", 32'(ex_reg_write), 32'd0);
      check("rst_mem_read", 32'(ex_mem_read), 32'd0);
`ifdef STALL_COUNTER_EN
      check("rst_stall_count", stall_count, 32'd0);
`endif
      reset   = 1'b0;
      ex_hold = 1'b0;

      // Plain ADD capture, B from rt.
      cap(4'b0011, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
      push_exp(1'b1, 4'b0011, 32'd5, 32'd7);
      step();
      check("add_rd_addr", 32'(ex_rd_addr), 32'd3);
      check("add_reg_write", 32'(ex_reg_write), 32'd1);

      // Immediate selected for B.
      cap(4'b0011, 32'h10, 32'h99, 32'h100, 1'b1, 1'b0, 5'd4, 5'd6, 5'd7, 1'b1, 1'b0);
      push_exp(1'b1, 4'b0011, 32'h10, 32'h100);
      step();
      check("imm_store", ex_store_data, 32'h99);

      // Random captures with no forwarding and no loads.
      for (int i = 0; i < 6; i++) begin
         r_op  = 4'($urandom_range(0, 4));
         r_rs  = $urandom;
         r_rt  = $urandom;
         r_imm = $urandom;
         r_src = 1'($urandom_range(0, 1));
         cap(r_op, r_rs, r_rt, r_imm, r_src, 1'b1, 5'($urandom_range(1, 31)),
             5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)), 1'b1, 1'b0);
         push_exp(1'b1, r_op, r_rs, r_src ? r_imm : r_rt);
         step();
      end

      // Double forwarding onto rs=r8, then EX/MEM onto rt=r4.
      cap(4'b0001, 32'hAA, 32'hBB, 32'd0, 1'b0, 1'b1, 5'd8, 5'd4, 5'd5, 1'b1, 1'b0);
      push_exp(1'b1, 4'b0001, 32'hAA, 32'hBB);
      step();
      idle_id();
      exmem_reg_write = 1'b1; exmem_rd_addr = 5'd8; exmem_result = 32'h11;
      memwb_reg_write = 1'b1; memwb_rd_addr = 5'd8; memwb_result = 32'h22;
      #1 check("fwd_both_a", A, 32'h11);
      exmem_reg_write = 1'b0;
      #1 check("fwd_memwb_a", A, 32'h22);
      exmem_reg_write = 1'b1; exmem_rd_addr = 5'd4;
      #1 check("fwd_exmem_b", B, 32'h11);
      check("fwd_exmem_store", ex_store_data, 32'h11);
      idle_fwd();

      // Register 0 is never forwarded.
      cap(4'b0000, 32'h33, 32'h44, 32'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
      push_exp(1'b1, 4'b0000, 32'h33, 32'h44);
      step();
      idle_id();
      exmem_reg_write = 1'b1; exmem_rd_addr = 5'd0; exmem_result = 32'h11;
      memwb_reg_write = 1'b1; memwb_rd_addr = 5'd0; memwb_result = 32'h22;
      #1 check("r0_a", A, 32'h33);
      check("r0_b", B, 32'h44);
      idle_fwd();

      // Load-use: lw r9 in the stage, add reading r9 in ID.
      cap(4'b0011, 32'd100, 32'd0, 32'd4, 1'b1, 1'b0, 5'd1, 5'd0, 5'd9, 1'b1, 1'b1);
      push_exp(1'b1, 4'b0011, 32'd100, 32'd4);
      step();
      check("lw_mem_read", 32'(ex_mem_read), 32'd1);
      cap(4'b0011, 32'h50, 32'h60, 32'd0, 1'b0, 1'b1, 5'd9, 5'd2, 5'd10, 1'b1, 1'b0);
      #1 check("lu_stall", 32'(stall_id), 32'd1);
      push_exp(1'b0, 4'd0, 32'd0, 32'd0);
      push_exp(1'b1, 4'b0011, 32'h50, 32'h60);
      step();
      check("bubble_reg_write", 32'(ex_reg_write), 32'd0);
      check("bubble_stall", 32'(stall_id), 32'd0);
      step();

      // Load whose rt match is ignored because the consumer does not read rt.
      cap(4'b0011, 32'd8, 32'd0, 32'd12, 1'b1, 1'b0, 5'd1, 5'd0, 5'd9, 1'b1, 1'b1);
      push_exp(1'b1, 4'b0011, 32'd8, 32'd12);
      step();
      cap(4'b0011, 32'h70, 32'h77, 32'd0, 1'b0, 1'b0, 5'd1, 5'd9, 5'd11, 1'b1, 1'b0);
      #1 check("no_rt_stall", 32'(stall_id), 32'd0);
      push_exp(1'b1, 4'b0011, 32'h70, 32'h77);
      step();

      // Flush together with hold kills the capture.
      cap(4'b0100, 32'h1, 32'h2, 32'd0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
      flush = 1'b1; ex_hold = 1'b1;
      push_exp(1'b0, 4'd0, 32'd0, 32'd0);
      step();
      check("flush_reg_write", 32'(ex_reg_write), 32'd0);
      flush = 1'b0; ex_hold = 1'b0;

      // Hold alone for three cycles freezes outputs.
      cap(4'b0100, 32'h900, 32'h300, 32'd0, 1'b0, 1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0);
      push_exp(1'b1, 4'b0100, 32'h900, 32'h300);
      step();
      ex_hold = 1'b1;
      cap(4'b0001, 32'h123, 32'h456, 32'd0, 1'b0, 1'b1, 5'd6, 5'd7, 5'd8, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1 check("hold_stall", 32'(stall_id), 32'd1);
         push_exp(1'b1, 4'b0100, 32'h900, 32'h300);
         step();
         check("hold_rd_addr", 32'(ex_rd_addr), 32'd5);
      end
      ex_hold = 1'b0;
      push_exp(1'b1, 4'b0001, 32'h123, 32'h456);
      step();

      // Reset in the middle of a load-use stall.
      cap(4'b0011, 32'd40, 32'd0, 32'd8, 1'b1, 1'b0, 5'd2, 5'd0, 5'd9, 1'b1, 1'b1);
      push_exp(1'b1, 4'b0011, 32'd40, 32'd8);
      step();
      cap(4'b0011, 32'h5, 32'h6, 32'd0, 1'b0, 1'b1, 5'd9, 5'd3, 5'd12, 1'b1, 1'b0);
      #1 check("pre_rst_stall", 32'(stall_id), 32'd1);
      reset = 1'b1;
      #1 check("rst_forces_stall_low", 32'(stall_id), 32'd0);
      push_exp(1'b0, 4'd0, 32'd0, 32'd0);
      step();
      check("mid_rst_rd_addr", 32'(ex_rd_addr), 32'd0);
      check("mid_rst_store", ex_store_data, 32'd0);
      check("mid_rst_mem_read", 32'(ex_mem_read), 32'd0);
      reset = 1'b0;
      idle_id();
`ifdef STALL_COUNTER_EN
      check("cnt_after_rst", stall_count, 32'd0);
`endif

      // Three independent load-use stalls, one bubble each.
      for (int i = 0; i < 3; i++) begin
         r_rs = $urandom;
         r_rt = $urandom;
         cap(4'b0011, 32'd16, 32'd0, 32'd4, 1'b1, 1'b0, 5'd1, 5'd0, 5'd13, 1'b1, 1'b1);
         push_exp(1'b1, 4'b0011, 32'd16, 32'd4);
         step();
         cap(4'b0100, r_rs, r_rt, 32'd0, 1'b0, 1'b1, 5'd2, 5'd13, 5'd14, 1'b1, 1'b0);
         #1 check("loop_stall", 32'(stall_id), 32'd1);
         push_exp(1'b0, 4'd0, 32'd0, 32'd0);
         push_exp(1'b1, 4'b0100, r_rs, r_rt);
         step();
         step();
      end
`ifdef STALL_COUNTER_EN
      check("cnt_three", stall_count, 32'd3);
`endif
      idle_id();

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
